config_manager_uc: RTL and testbench

Control unit that sequences the configuration datapath: the serial config receiver and the five 16-bit limit registers (humidity, temp1..temp4).
- Each configuration transaction is two 16-bit words: a header selecting the target register, then the value word.
- Validates header, parity and inter-word timing, then pulses exactly one register load.
- Tracks which limits have been written since reset and reports errors and FSM state for debug.

---
 rtl/config_manager_uc.sv | 166 ++++++++++++++++
 tb/tb_config_manager_uc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_manager_uc.sv
// Control unit for the serial configuration path: validates header/data word pairs
// and pulses exactly one limit-register load per good transaction.
module config_manager_uc #(
  parameter int unsigned TIMEOUT_CICLOS = 50000000,
  parameter logic [7:0]  MAGICO         = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita_config,
  input  logic        fim_recepcao_config,
  input  logic        parity_config_ok,
  input  logic [15:0] dado_config,
  output logic        load_lim_um,
  output logic        load_temp1,
  output logic        load_temp2,
  output logic        load_temp3,
  output logic        load_temp4,
  output logic        config_concluida,
  output logic        erro_config,
  output logic [1:0]  codigo_erro,
  output logic [4:0]  configurados,
  output logic        todos_configurados,
  output logic [2:0]  db_estado
);

  localparam int unsigned CW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

  localparam logic [1:0] ERR_PARIDADE  = 2'b01;
  localparam logic [1:0] ERR_CABECALHO = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO           = 3'd0,
    ESPERA_CABECALHO = 3'd1,
    DECODIFICA       = 3'd2,
    ESPERA_DADO      = 3'd3,
    CARREGA          = 3'd4,
    FIM              = 3'd5,
    ERRO             = 3'd6
  } estado_t;

  estado_t       estado, proximo;
  logic [7:0]    magico_q;
  logic [2:0]    alvo;
  logic [CW-1:0] contador;
  logic          latch_cab;
  logic          set_erro;
  logic [1:0]    erro_novo;
  logic [4:0]    carga;

  // Only bits [15:8] and [2:0] of a header carry meaning.
  logic unused_bits;
  assign unused_bits = ^dado_config[7:3];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    proximo   = estado;
    latch_cab = 1'b0;
    set_erro  = 1'b0;
    erro_novo = 2'b00;
    case (estado)
      OCIOSO:
        if (habilita_config) proximo = ESPERA_CABECALHO;
      ESPERA_CABECALHO:
        if (fim_recepcao_config) begin
          if (parity_config_ok) begin
            latch_cab = 1'b1;
            proximo   = DECODIFICA;
          end else begin
            set_erro  = 1'b1;
            erro_novo = ERR_PARIDADE;
            proximo   = ERRO;
          end
        end
      DECODIFICA:
        if (magico_q == MAGICO && alvo <= 3'd4) begin
          proximo = ESPERA_DADO;
        end else begin
          set_erro  = 1'b1;
          erro_novo = ERR_CABECALHO;
          proximo   = ERRO;
        end
      ESPERA_DADO:
        // An arriving word takes priority over an expiring timeout.
        if (fim_recepcao_config) begin
          if (parity_config_ok) begin
            proximo = CARREGA;
          end else begin
            set_erro  = 1'b1;
            erro_novo = ERR_PARIDADE;
            proximo   = ERRO;
          end
        end else if (contador == LIMITE) begin
          set_erro  = 1'b1;
          erro_novo = ERR_TIMEOUT;
          proximo   = ERRO;
        end
      CARREGA: proximo = FIM;
      FIM:     proximo = habilita_config ? ESPERA_CABECALHO : OCIOSO;
      ERRO:    proximo = ESPERA_CABECALHO;
      default: proximo = OCIOSO;
    endcase

    // Dropping the enable aborts silently, except a load already under way completes.
    if (!habilita_config && estado != CARREGA && estado != FIM) begin
      proximo   = OCIOSO;
      latch_cab = 1'b0;
      set_erro  = 1'b0;
    end
  end

  always_comb begin
    carga = 5'b00000;
    if (estado == CARREGA) begin
      case (alvo)
        3'd0:    carga = 5'b00001;
        3'd1:    carga = 5'b00010;
        3'd2:    carga = 5'b00100;
        3'd3:    carga = 5'b01000;
        3'd4:    carga = 5'b10000;
        default: carga = 5'b00000;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      magico_q     <= 8'h00;
      alvo         <= 3'd0;
      contador     <= '0;
      codigo_erro  <= 2'b00;
      configurados <= 5'b00000;
    end else begin
      estado <= proximo;
      if (latch_cab) begin
        magico_q <= dado_config[15:8];
        alvo     <= dado_config[2:0];
      end
      if (estado == DECODIFICA) begin
        contador <= '0;
      end else if (estado == ESPERA_DADO) begin
        contador <= contador + CW'(1);
      end
      if (set_erro) begin
        codigo_erro <= erro_novo;
      end else if (estado == FIM) begin
        codigo_erro <= 2'b00;
      end
      configurados <= configurados | carga;
    end
  end

  assign load_lim_um        = carga[0];
  assign load_temp1         = carga[1];
  assign load_temp2         = carga[2];
  assign load_temp3         = carga[3];
  assign load_temp4         = carga[4];
  assign config_concluida   = (estado == FIM);
  assign erro_config        = (estado == ERRO);
  assign todos_configurados = &configurados;
  assign db_estado          = estado;

endmodule

// File: tb/tb_config_manager_uc.sv
// Directed self-checking bench for config_manager_uc with a short timeout (100 cycles).
module tb_config_manager_uc;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita_config;
  logic        fim_recepcao_config;
  logic        parity_config_ok;
  logic [15:0] dado_config;
  logic        load_lim_um, load_temp1, load_temp2, load_temp3, load_temp4;
  logic        config_concluida, erro_config, todos_configurados;
  logic [1:0]  codigo_erro;
  logic [4:0]  configurados;
  logic [2:0]  db_estado;

  int n_checks = 0;
  int n_errors = 0;

  config_manager_uc #(.TIMEOUT_CICLOS(100), .MAGICO(8'hA5)) dut (
    .clock               (clock),
    .reset               (reset),
    .habilita_config     (habilita_config),
    .fim_recepcao_config (fim_recepcao_config),
    .parity_config_ok    (parity_config_ok),
    .dado_config         (dado_config),
    .load_lim_um         (load_lim_um),
    .load_temp1          (load_temp1),
    .load_temp2          (load_temp2),
    .load_temp3          (load_temp3),
    .load_temp4          (load_temp4),
    .config_concluida    (config_concluida),
    .erro_config         (erro_config),
    .codigo_erro         (codigo_erro),
    .configurados        (configurados),
    .todos_configurados  (todos_configurados),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  wire [4:0] loads = {load_temp4, load_temp3, load_temp2, load_temp1, load_lim_um};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic p);
    dado_config         = w;
    parity_config_ok    = p;
    fim_recepcao_config = 1'b1;
    tick();
    fim_recepcao_config = 1'b0;
    parity_config_ok    = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    habilita_config     = 1'b0;
    fim_recepcao_config = 1'b0;
    parity_config_ok    = 1'b0;
    dado_config         = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    check("rst_estado", db_estado, 3'd0);
    check("rst_config", configurados, 5'b00000);
    check("rst_codigo", codigo_erro, 2'b00);
    check("rst_loads", loads, 5'b00000);
    check("rst_flags", {erro_config, config_concluida, todos_configurados}, 3'b000);

    // Valid transaction to temp2
    habilita_config = 1'b1;
    tick();
    check("hab_estado", db_estado, 3'd1);
    send_word(16'hA502, 1'b1);
    check("cab_estado", db_estado, 3'd2);
    tick();
    check("dec_estado", db_estado, 3'd3);
    send_word(16'h0123, 1'b1);
    check("t2_load", loads, 5'b00100);
    check("t2_estado", db_estado, 3'd4);
    tick();
    check("t2_load_off", loads, 5'b00000);
    check("t2_concl", config_concluida, 1'b1);
    check("t2_config", configurados, 5'b00100);
    tick();
    check("t2_volta", db_estado, 3'd1);
    check("t2_concl_off", config_concluida, 1'b0);
    check("t2_codigo", codigo_erro, 2'b00);

    // Header parity error
    send_word(16'hA501, 1'b0);
    check("par_erro", erro_config, 1'b1);
    check("par_codigo", codigo_erro, 2'b01);
    tick();
    check("par_volta", db_estado, 3'd1);
    check("par_erro_off", erro_config, 1'b0);

    // Bad index
    send_word(16'hA507, 1'b1);
    tick();
    check("idx_erro", erro_config, 1'b1);
    check("idx_codigo", codigo_erro, 2'b10);
    check("idx_loads", loads, 5'b00000);
    tick();
    check("idx_volta", db_estado, 3'd1);

    // Bad magic
    send_word(16'h5A01, 1'b1);
    tick();
    check("mag_erro", erro_config, 1'b1);
    check("mag_codigo", codigo_erro, 2'b10);
    tick();
    check("mag_volta", db_estado, 3'd1);
    check("mag_config", configurados, 5'b00100);

    // Timeout: 100 cycles in ESPERA_DADO with no word
    send_word(16'hA500, 1'b1);
    tick();
    begin
      int lim_vistos = 0;
      for (int i = 0; i < 99; i++) begin
        if (load_lim_um) lim_vistos++;
        tick();
      end
      check("to_ainda_espera", db_estado, 3'd3);
      tick();
      if (load_lim_um) lim_vistos++;
      check("to_erro", erro_config, 1'b1);
      check("to_codigo", codigo_erro, 2'b11);
      check("to_sem_load", lim_vistos, 0);
      tick();
      check("to_volta", db_estado, 3'd1);
    end

    // Data on the last allowed cycle wins over the timeout
    send_word(16'hA500, 1'b1);
    tick();
    for (int i = 0; i < 99; i++) tick();
    send_word(16'h00FF, 1'b1);
    check("to99_load", loads, 5'b00001);
    check("to99_sem_erro", erro_config, 1'b0);
    tick();
    check("to99_config", configurados, 5'b00101);
    tick();
    check("to99_codigo", codigo_erro, 2'b00);

    // Full configuration from a clean reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_config", configurados, 5'b00000);
    tick();
    for (int idx = 0; idx < 5; idx++) begin
      logic [15:0] cab;
      logic [4:0]  mask_esp;
      logic [4:0]  conf_esp;
      cab      = {8'hA5, 5'b00000, 3'(idx)};
      mask_esp = 5'(1 << idx);
      conf_esp = 5'((1 << (idx + 1)) - 1);
      send_word(cab, 1'b1);
      tick();
      send_word(16'h1000 + 16'(idx), 1'b1);
      check($sformatf("full_load%0d", idx), loads, mask_esp);
      tick();
      check($sformatf("full_config%0d", idx), configurados, conf_esp);
      check($sformatf("full_todos%0d", idx), todos_configurados, (idx == 4));
      tick();
    end

    // Abort while waiting for data
    send_word(16'hA503, 1'b1);
    tick();
    check("ab_espera", db_estado, 3'd3);
    habilita_config = 1'b0;
    tick();
    check("ab_ocioso", db_estado, 3'd0);
    check("ab_sem_pulsos", {loads, erro_config}, 6'b000000);
    tick();
    check("ab_sem_pulsos2", {loads, erro_config, config_concluida}, 7'b0000000);

    // Enable dropped during CARREGA: load still completes
    habilita_config = 1'b1;
    tick();
    send_word(16'hA501, 1'b1);
    tick();
    send_word(16'hBEEF, 1'b1);
    habilita_config = 1'b0;
    check("abc_load", loads, 5'b00010);
    tick();
    check("abc_concl", config_concluida, 1'b1);
    tick();
    check("abc_ocioso", db_estado, 3'd0);

    // Synchronous reset in ESPERA_DADO with a data pulse on the same edge
    habilita_config = 1'b1;
    tick();
    send_word(16'hA504, 1'b1);
    tick();
    check("rs_espera", db_estado, 3'd3);
    reset = 1'b1;
    send_word(16'h4444, 1'b1);
    check("rs_estado", db_estado, 3'd0);
    check("rs_config", configurados, 5'b00000);
    check("rs_loads", loads, 5'b00000);
    reset = 1'b0;
    tick();
    check("rs_loads2", loads, 5'b00000);
    check("rs_volta", db_estado, 3'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
